imem_port_arbiter: RTL
======================

# imem_port_arbiter

Sequencer and arbiter for the single-ported memory shared by the fetch stage and the load/store path. It accepts instruction fetches and data accesses and grants one at a time to the memory port. It gives data priority, with a streak limit so fetch cannot starve. It drives the fetch stage's clock enable so the instruction pointer advances only when a fetched word is delivered, and it aborts accesses that never get an acknowledge.

## Interface
- DATA_STREAK, 4: maximum consecutive data grants while fetch_req is pending; range 1..15.
- TIMEOUT, 255: wait cycles without mem_ack before abort; range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch wants a word; held high until fetch_en.
- fetch_addr  in  30  word address (fetch stage inst_addr).
- fetch_en  out  1  one-cycle clock-enable pulse to fetch stage.
- inst_data  out  32  fetched word; valid while inst_valid.
- inst_valid  out  1  one-cycle pulse, coincident with fetch_en.
- d_req  in  1  data access request; held high until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  30  data word address.
- d_wdata  in  32  write data.
- d_be  in  4  byte enables.
- d_done  out  1  one-cycle completion pulse.
- d_rdata  out  32  read data; valid while d_done.
- bus_err  out  1  one-cycle pulse on timeout, coincident with fetch_en or d_done.
- mem_req  out  1  memory request; held until acked or aborted.
- mem_we, mem_addr[29:0], mem_wdata[31:0], mem_be[3:0]  out  memory command; registered and stable while mem_req is high.
- mem_ack  in  1  memory completion, sampled on clk while mem_req is high.
- mem_rdata  in  32  read data, valid with mem_ack.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, FETCH, DATA.
- In IDLE, grant DATA if d_req is high and either fetch_req is low or streak < DATA_STREAK. Otherwise grant FETCH if fetch_req is high. Otherwise stay in IDLE.
- On grant:
  - Latch the command into the mem_* registers. For a fetch: mem_we=0, mem_be=4'hF, mem_wdata=0.
  - Clear the wait counter.
  - Update streak: increment on a data grant when fetch_req is high (saturate at DATA_STREAK); clear on a fetch grant or when fetch_req is low.
- In FETCH or DATA with mem_ack high:
  - Capture mem_rdata into inst_data or d_rdata.
  - Pulse fetch_en with inst_valid, or pulse d_done.
  - Deassert mem_req and return to IDLE.
- In FETCH or DATA without mem_ack: increment the wait counter. When it reaches TIMEOUT:
  - Deassert mem_req and pulse bus_err.
  - Fetch: pulse fetch_en with inst_valid=0; the fetch stage must hold its ip.
  - Data: pulse d_done with d_rdata=0.
  - Return to IDLE.
- d_we, d_be and d_wdata are ignored outside the grant cycle.
- Reset (rst=0): immediately state=IDLE and all outputs 0. This includes mem_req and the mem_* registers, inst_data, d_rdata and streak. An in-flight access is abandoned without any completion pulse.

## Timing
- Grant decision happens on the clk edge in IDLE; mem_req is high from the next cycle.
- Minimum transaction is 2 cycles: 1 IDLE cycle plus 1 request cycle with mem_ack already high.
- Peak throughput is one access per 2 cycles.
- Completion pulses (fetch_en, inst_valid, d_done, bus_err) are registered. They are high exactly in the cycle after the mem_ack edge, which is also the IDLE cycle.
- A new request raised in that cycle is granted at the end of it.
- Timeout fires on the edge where the wait counter equals TIMEOUT, i.e. mem_req has been high for TIMEOUT+1 cycles.
- If mem_ack arrives on the same edge as the timeout, the ack wins: normal completion, no bus_err.
- If fetch_req and d_req rise in the same IDLE cycle with streak < DATA_STREAK, data wins.
- mem_ack while mem_req is low is ignored.
- Widths: streak counter is 4 bits, wait counter is 8 bits, both unsigned with no wrap (saturate and compare).

## Structure
- Shared package srm_mem_pkg: ADDR_W=30, DATA_W=32, BE_W=4, and the arb_state_t enum {IDLE, FETCH, DATA}. The fetch stage and load/store unit import the widths from it.
- One sub-module, mem_watchdog: an 8-bit wait counter with clear, enable and TIMEOUT compare, producing a timeout strobe.
- Arbitration, FSM and output registers live in the top module.

## Test plan
- Reset mid-DATA with mem_req high, then rst=0: mem_req drops in the same cycle; no d_done; after rst=1, busy=0 and all outputs 0.
- fetch_req only, fetch_addr=0x0000010, mem_ack one cycle after mem_req with rdata=0xDEADBEEF: mem_addr=0x10 and mem_we=0; fetch_en and inst_valid pulse with inst_data=0xDEADBEEF 3 cycles after the request.
- d_req write, d_addr=0x20, d_wdata=0x12345678, d_be=4'b0011, immediate ack: mem_we=1 with matching mem_* values; d_done pulses once; fetch_en stays 0.
- fetch_req and d_req held high continuously, DATA_STREAK=4, ack always immediate: grant sequence D,D,D,D,F,D,D,D,D,F.
- mem_ack never asserted, TIMEOUT=255, fetch access: mem_req high for exactly 256 cycles, then bus_err and fetch_en pulse with inst_valid=0; the fetch is regranted next.
- mem_ack on the same edge as the timeout: normal completion with rdata delivered and bus_err=0.

Source files
------------

// File: rtl/srm_mem_pkg.sv
// Shared widths, arbiter state encoding and small helpers for the single-ported
// memory shared by the fetch stage and the load/store path.
package srm_mem_pkg;

    localparam int ADDR_W   = 30;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int STREAK_W = 4;
    localparam int WAIT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Saturating increment of the data streak counter; never exceeds lim.
    function automatic logic [STREAK_W-1:0] streak_sat_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] lim
    );
        logic [STREAK_W-1:0] res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, data and memory-port signal bundle of the memory arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface imem_port_arbiter_if;
    import srm_mem_pkg::*;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_en;
    logic [DATA_W-1:0] inst_data;
    logic              inst_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              bus_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  fetch_req, fetch_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output fetch_en, inst_data, inst_valid,
        output d_done, d_rdata, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output busy
    );

    modport master (
        output fetch_req, fetch_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  fetch_en, inst_data, inst_valid,
        input  d_done, d_rdata, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  busy
    );

endinterface

// File: rtl/mem_watchdog.sv
// Wait counter for an outstanding memory request; flags when it has sat at
// TIMEOUT, i.e. the request has been pending for TIMEOUT+1 cycles.
module mem_watchdog
    import srm_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] cnt_s;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = 8'd0;
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_s = cnt_r + 8'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign timeout = (cnt_r == LIMIT);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch and
// load/store. Data has priority, bounded by a streak limit while fetch waits.
module imem_port_arbiter
    import srm_mem_pkg::*;
#(
    parameter int unsigned DATA_STREAK = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(DATA_STREAK);

    arb_state_t          state_r,      state_s;
    logic [STREAK_W-1:0] streak_r,     streak_s;
    logic                mem_req_r,    mem_req_s;
    logic                mem_we_r,     mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r,   mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r,  mem_wdata_s;
    logic [BE_W-1:0]     mem_be_r,     mem_be_s;
    logic [DATA_W-1:0]   inst_data_r,  inst_data_s;
    logic [DATA_W-1:0]   d_rdata_r,    d_rdata_s;
    logic                fetch_en_r,   fetch_en_s;
    logic                inst_valid_r, inst_valid_s;
    logic                d_done_r,     d_done_s;
    logic                bus_err_r,    bus_err_s;
    logic                busy_r,       busy_s;

    logic                grant_data_s;
    logic                wd_clr_s;
    logic                wd_en_s;
    logic                wd_timeout_s;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .timeout (wd_timeout_s)
    );

    // Data wins unless fetch is waiting and the data streak is exhausted.
    always_comb begin
        grant_data_s = bus.d_req && (!bus.fetch_req || (streak_r < STREAK_LIM));
    end

    // Next-state, command latch and completion-pulse logic.
    always_comb begin
        state_s      = state_r;
        streak_s     = streak_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_be_s     = mem_be_r;
        inst_data_s  = inst_data_r;
        d_rdata_s    = d_rdata_r;
        fetch_en_s   = 1'b0;
        inst_valid_s = 1'b0;
        d_done_s     = 1'b0;
        bus_err_s    = 1'b0;
        wd_clr_s     = 1'b0;
        wd_en_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (grant_data_s) begin
                    state_s     = DATA;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.d_we;
                    mem_addr_s  = bus.d_addr;
                    mem_wdata_s = bus.d_wdata;
                    mem_be_s    = bus.d_be;
                    wd_clr_s    = 1'b1;
                    if (bus.fetch_req) begin
                        streak_s = streak_sat_inc(streak_r, STREAK_LIM);
                    end else begin
                        streak_s = 4'd0;
                    end
                end else if (bus.fetch_req) begin
                    state_s     = FETCH;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.fetch_addr;
                    mem_wdata_s = 32'h0000_0000;
                    mem_be_s    = 4'hF;
                    wd_clr_s    = 1'b1;
                    streak_s    = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end

            FETCH: begin
                // An ack on the timeout edge still counts as a normal completion.
                if (bus.mem_ack) begin
                    state_s      = IDLE;
                    mem_req_s    = 1'b0;
                    inst_data_s  = bus.mem_rdata;
                    fetch_en_s   = 1'b1;
                    inst_valid_s = 1'b1;
                end else if (wd_timeout_s) begin
                    state_s      = IDLE;
                    mem_req_s    = 1'b0;
                    fetch_en_s   = 1'b1;
                    inst_valid_s = 1'b0;
                    bus_err_s    = 1'b1;
                end else begin
                    wd_en_s = 1'b1;
                end
            end

            DATA: begin
                if (bus.mem_ack) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                    d_rdata_s = bus.mem_rdata;
                    d_done_s  = 1'b1;
                end else if (wd_timeout_s) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                    d_rdata_s = 32'h0000_0000;
                    d_done_s  = 1'b1;
                    bus_err_s = 1'b1;
                end else begin
                    wd_en_s = 1'b1;
                end
            end

            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset abandons any in-flight access silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            streak_r     <= 4'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 30'd0;
            mem_wdata_r  <= 32'h0000_0000;
            mem_be_r     <= 4'h0;
            inst_data_r  <= 32'h0000_0000;
            d_rdata_r    <= 32'h0000_0000;
            fetch_en_r   <= 1'b0;
            inst_valid_r <= 1'b0;
            d_done_r     <= 1'b0;
            bus_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            streak_r     <= streak_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_be_r     <= mem_be_s;
            inst_data_r  <= inst_data_s;
            d_rdata_r    <= d_rdata_s;
            fetch_en_r   <= fetch_en_s;
            inst_valid_r <= inst_valid_s;
            d_done_r     <= d_done_s;
            bus_err_r    <= bus_err_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_be     = mem_be_r;
    assign bus.inst_data  = inst_data_r;
    assign bus.inst_valid = inst_valid_r;
    assign bus.fetch_en   = fetch_en_r;
    assign bus.d_rdata    = d_rdata_r;
    assign bus.d_done     = d_done_r;
    assign bus.bus_err    = bus_err_r;
    assign bus.busy       = busy_r;

endmodule
